tick_updown_counter: RTL
========================

TICK_UPDOWN_COUNTER -- requirements
Module: tick_updown_counter

Interface
REQ-001 Parameter WIDTH, 4, counter width in bits; SHALL be >= 1.
REQ-002 Parameter DIV, 33554432, prescale ratio in CLOCK_50 cycles per count step; SHALL be >= 1.
REQ-003 Parameter RESET_VAL, 0, counter value after reset; SHALL be truncated to WIDTH bits.
REQ-004 Port CLOCK_50  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port en  input  1  count enable; 0 freezes the prescaler and the counter.
REQ-007 Port dir  input  1  1 = count up, 0 = count down.
REQ-008 Port load  input  1  synchronous parallel load request.
REQ-009 Port load_val  input  WIDTH  value to load.
REQ-010 Port out  output  WIDTH  registered counter value.
REQ-011 Port tick  output  1  combinational step strobe, = en && (presc == DIV-1).
REQ-012 Port tc  output  1  registered terminal-count pulse, one cycle wide.

Function
REQ-013 Prescaler: internal counter presc, width clog2(DIV) (min 1), SHALL count 0..DIV-1 while en=1 and wrap to 0 after DIV-1; held while en=0.
REQ-014 DIV=1 SHALL give tick=en every cycle; no derived or gated clock SHALL exist.
REQ-015 Priority per edge: reset > load > step > hold.
REQ-016 load=1: out <= load_val, presc <= 0, tc <= 0, independent of en, dir and tick.
REQ-017 Step (load=0, tick=1): dir=1 gives out+1, dir=0 gives out-1, modulo 2^WIDTH.
REQ-018 Otherwise out SHALL hold, and tc SHALL be 0.
REQ-019 tc SHALL be 1 for exactly the cycle after a step that crosses a boundary: up from 2^WIDTH-1, or down from 0.
REQ-020 Changing dir between ticks SHALL take effect at the next tick; no extra latency.
REQ-021 Latency: out and tc SHALL change on the same edge on which tick is sampled high.

Reset
REQ-022 On reset=1 at an edge: out <= RESET_VAL, presc <= 0, tc <= 0.
REQ-023 tick after reset SHALL be 0 when DIV>1, and equal to en when DIV=1.
REQ-024 Reset asserted mid-count or coincident with load or tick SHALL override both; there is no power-up behaviour beyond reset.

Configuration
REQ-025 Macro TICK_COUNTER_SAT_EN compiles in saturation.
REQ-026 When defined, a boundary-crossing step SHALL hold out at 2^WIDTH-1 (up) or 0 (down) and still pulse tc.
REQ-027 When undefined, the counter SHALL wrap per REQ-017.
REQ-028 Load and reset SHALL behave identically in both builds.

Structure
REQ-029 Package tick_counter_pkg SHALL hold the clog2 width helper, DIR_UP=1'b1, DIR_DOWN=1'b0 and DIV_50MHZ_1HZ=50000000.
REQ-030 The prescaler SHALL be a sub-module, tick_prescaler (params DIV; ports CLOCK_50, reset, en, clr, tick).
REQ-031 Total RTL SHALL be 120-400 lines, with no latches and no combinational loops.

Verification (WIDTH=4, DIV=3, RESET_VAL=0 unless noted)
REQ-032 Reset: assert reset 2 cycles with en=1 -> out=0, tc=0, tick=0; first tick 3 cycles after release; out=1 (dir=1) one edge later.
REQ-033 Wrap down: load 0, dir=0, en=1 -> after the 3rd cycle out=15, tc=1 for one cycle; next tick out=14, tc=0.
REQ-034 Wrap up, DIV=1: load 14, dir=1 -> out 15, 0 (tc=1), 1 on consecutive cycles; with TICK_COUNTER_SAT_EN -> 15, 15 (tc=1), 15 (tc=1).
REQ-035 Collision: load=1 (load_val=9) on a tick cycle -> out=9, tc=0, presc restarts; next step 3 cycles later.
REQ-036 Freeze: drop en for 5 cycles at presc=1 -> out and tick frozen; on re-enable, tick after 1 more cycle.
REQ-037 Reset mid-count: reset on a tick cycle with out=7, RESET_VAL=5 -> out=5, tc=0.

Source files
------------

// File: rtl/tick_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_counter_pkg
// Description : Shared constants and the prescaler width helper for the
//               tick-driven up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_counter_pkg;

    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;
    localparam int   DIV_50MHZ_1HZ = 50000000;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage : tick_counter_pkg
`default_nettype wire

// File: rtl/tick_updown_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : tick_updown_counter_if
// Description : Control and status bundle of the tick-driven up/down counter.
//               The master drives enable, direction and load; the slave
//               (the counter) returns the count, the step strobe and the
//               terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface tick_updown_counter_if #(
    parameter int WIDTH = 4
);

    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tick;
    logic             tc;

    modport master (
        output en, dir, load, load_val,
        input  out, tick, tc
    );

    modport slave (
        input  en, dir, load, load_val,
        output out, tick, tc
    );

endinterface : tick_updown_counter_if
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running 0..DIV-1 prescaler producing a single-cycle step
//               strobe. No derived clock: the strobe is an enable in the
//               CLOCK_50 domain. DIV=1 makes the strobe equal to en.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import tick_counter_pkg::*;
#(
    parameter int DIV = 33554432
) (
    input  wire logic CLOCK_50,
    input  wire logic reset,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick
);

    localparam int            PW     = clog2_min1(DIV);
    localparam logic [PW-1:0] c_LAST = PW'(DIV - 1);

    logic [PW-1:0] r_presc;

    // Strobe is combinational so the counter steps on the same edge it is seen.
    assign tick = en && (r_presc == c_LAST);

    // Count while enabled, wrap after the last phase; reset/clear restart at 0.
    always_ff @(posedge CLOCK_50) begin
        if (reset || clr) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= tick ? '0 : r_presc + 1'b1;
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/tick_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tick_updown_counter
// Description : WIDTH-bit up/down counter stepped by a DIV-cycle prescaler.
//               Edge priority is reset > load > step > hold. tc pulses for
//               one cycle after a step that crosses the top (up) or bottom
//               (down) of the range.
//               Build option: define TICK_COUNTER_SAT_EN to saturate at the
//               range ends instead of wrapping (tc still pulses).
// Revision    : 1.0 - initial release
// ============================================================================
module tick_updown_counter
    import tick_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV       = 33554432,
    parameter int RESET_VAL = 0
) (
    input  wire logic            CLOCK_50,
    input  wire logic            reset,
    tick_updown_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] c_RESET_VAL = WIDTH'(RESET_VAL);

    logic             w_tick;
    logic             w_cross;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_out;
    logic             r_tc;

    // A load restarts the prescaler phase so the next step is a full DIV away.
    tick_prescaler #(
        .DIV      (DIV)
    ) u_prescaler (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (bus.en),
        .clr      (bus.load),
        .tick     (w_tick)
    );

    // Boundary detection depends on the direction in force at this step.
    assign w_cross = (bus.dir == DIR_UP) ? (r_out == '1) : (r_out == '0);

`ifdef TICK_COUNTER_SAT_EN
    // Saturating build: a crossing step leaves the count pinned at the end.
    assign w_next = w_cross ? r_out
                  : ((bus.dir == DIR_UP) ? r_out + 1'b1 : r_out - 1'b1);
`else
    // Wrapping build: modulo 2^WIDTH arithmetic.
    assign w_next = (bus.dir == DIR_UP) ? r_out + 1'b1 : r_out - 1'b1;
`endif

    // Count register and terminal-count pulse, reset > load > step > hold.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_out <= c_RESET_VAL;
            r_tc  <= 1'b0;
        end else if (bus.load) begin
            r_out <= bus.load_val;
            r_tc  <= 1'b0;
        end else if (w_tick) begin
            r_out <= w_next;
            r_tc  <= w_cross;
        end else begin
            r_tc  <= 1'b0;
        end
    end

    assign bus.out  = r_out;
    assign bus.tc   = r_tc;
    assign bus.tick = w_tick;

endmodule : tick_updown_counter
`default_nettype wire
